// File: rtl/sortmax_arb_pkg.sv
// Shared types and constants for the sortmax time-sharing arbiter.
package sortmax_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FRST = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int unsigned X_W = 5;
  localparam int unsigned Y_W = 20;

  // One-hot grant vector for a requester index.
  function automatic logic [1:0] req_onehot(input logic idx);
    return (idx == REQ_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sortmax_rr_pick.sv
// Two-way round-robin winner selection: the requester that did not own
// the previous burst wins when it is requesting.
module sortmax_rr_pick
  import sortmax_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       vld,
  output logic       win
);

  // Prefer the requester other than rr_last, else whoever is requesting.
  always_comb begin
    vld = |req;
    win = REQ_A;
    if (req[~rr_last])
      win = ~rr_last;
    else if (req[REQ_B])
      win = REQ_B;
    else
      win = REQ_A;
  end

endmodule

// File: rtl/sortmax_arb.sv
// Time-shares one sortmax FSM between requesters A and B with round-robin
// grants, bounded bursts and a fresh FSM reset at every handoff.
module sortmax_arb
  import sortmax_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN = 8,
  parameter logic        KEY_RST   = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req,
  input  logic [X_W-1:0] x_a,
  input  logic [X_W-1:0] x_b,
  input  logic           key_we,
  input  logic           key_din,
  output logic [1:0]     gnt,
  output logic [X_W-1:0] fsm_x,
  output logic           fsm_rst,
  output logic           fsm_key,
  input  logic [Y_W-1:0] fsm_y,
  output logic [Y_W-1:0] y_out,
  output logic           y_vld,
  output logic           y_owner,
  output logic           key_err
);

  arb_state_t     state;
  logic           owner;
  logic           rr_last;
  logic [7:0]     cnt;
  logic           key_reg;
  logic           pick_vld;
  logic           pick_win;
  logic [X_W-1:0] x_own;

  sortmax_rr_pick u_pick (
    .req     (req),
    .rr_last (rr_last),
    .vld     (pick_vld),
    .win     (pick_win)
  );

  // Owner's inputs routed toward the FSM.
  always_comb begin
    x_own = (owner == REQ_B) ? x_b : x_a;
  end

  assign fsm_key = key_reg;

  // Arbitration FSM; all outputs registered so they line up with the state.
  // y_vld is raised on the FRST->RUN edge so it is high exactly for the RUN cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= '0;
      fsm_x   <= '0;
      fsm_rst <= 1'b1;
      y_out   <= '0;
      y_vld   <= 1'b0;
      y_owner <= 1'b0;
      owner   <= REQ_A;
      rr_last <= REQ_B;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          fsm_rst <= 1'b1;
          gnt     <= '0;
          y_vld   <= 1'b0;
          if (pick_vld) begin
            owner <= pick_win;
            gnt   <= req_onehot(pick_win);
            state <= FRST;
          end
        end
        FRST: begin
          fsm_x   <= x_own;
          cnt     <= '0;
          fsm_rst <= 1'b0;
          y_out   <= fsm_y;
          y_vld   <= 1'b1;
          y_owner <= owner;
          state   <= RUN;
        end
        RUN: begin
          fsm_x <= x_own;
          y_out <= fsm_y;
          if (!req[owner] || cnt == 8'(BURST_LEN - 1)) begin
            gnt     <= '0;
            rr_last <= owner;
            y_vld   <= 1'b0;
            fsm_rst <= 1'b1;
            state   <= GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          fsm_rst <= 1'b1;
          gnt     <= '0;
          y_vld   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Key register writable only while idle; stray writes latch key_err.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_reg <= KEY_RST;
      key_err <= 1'b0;
    end else if (key_we) begin
      if (state == IDLE)
        key_reg <= key_din;
      else
        key_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sortmax_arb.sv
// Directed bench for sortmax_arb: reset, bursts, contention, early release,
// key protection and mid-burst reset.
module tb_sortmax_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [4:0]  x_a;
  logic [4:0]  x_b;
  logic        key_we;
  logic        key_din;
  logic [1:0]  gnt;
  logic [4:0]  fsm_x;
  logic        fsm_rst;
  logic        fsm_key;
  logic [19:0] fsm_y;
  logic [19:0] y_out;
  logic        y_vld;
  logic        y_owner;
  logic        key_err;

  int unsigned total;
  int unsigned bad;
  int unsigned ystep;

  sortmax_arb #(.BURST_LEN(8), .KEY_RST(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .x_a     (x_a),
    .x_b     (x_b),
    .key_we  (key_we),
    .key_din (key_din),
    .gnt     (gnt),
    .fsm_x   (fsm_x),
    .fsm_rst (fsm_rst),
    .fsm_key (fsm_key),
    .fsm_y   (fsm_y),
    .y_out   (y_out),
    .y_vld   (y_vld),
    .y_owner (y_owner),
    .key_err (key_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic newy();
    ystep++;
    fsm_y = {ystep[11:0], 8'h80};
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_frst"}, 32'(fsm_rst), 32'd1);
    chk({tag, "_yvld"}, 32'(y_vld), 32'd0);
  endtask

  task automatic run_chk(input string tag, input logic own, input logic [4:0] xe,
                         input logic [19:0] ye);
    chk({tag, "_gnt"}, 32'(gnt), own ? 32'd2 : 32'd1);
    chk({tag, "_frst"}, 32'(fsm_rst), 32'd0);
    chk({tag, "_yvld"}, 32'(y_vld), 32'd1);
    chk({tag, "_yown"}, 32'(y_owner), 32'(own));
    chk({tag, "_fx"}, 32'(fsm_x), 32'(xe));
    chk({tag, "_yout"}, 32'(y_out), 32'(ye));
    chk({tag, "_y8"}, 32'(y_out[7]), 32'd1);
  endtask

  // One RUN-producing edge: fresh x on the owner's input and fresh fsm_y.
  task automatic run_step(input string tag, input logic own, input logic [4:0] xv);
    logic [19:0] ye;
    if (own) x_b = xv; else x_a = xv;
    newy();
    ye = fsm_y;
    tick();
    run_chk(tag, own, xv, ye);
  endtask

  initial begin
    logic own;
    total = 0; bad = 0; ystep = 0;
    rst = 1'b0; req = 2'b00; x_a = '0; x_b = '0;
    key_we = 1'b0; key_din = 1'b0; fsm_y = '0;

    // Reset, then quiet idle.
    tick(); tick();
    idle_chk("rst");
    chk("rst_fx", 32'(fsm_x), 32'd0);
    chk("rst_yout", 32'(y_out), 32'd0);
    chk("rst_key", 32'(fsm_key), 32'd1);
    chk("rst_kerr", 32'(key_err), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      idle_chk("idle");
      chk("idle_key", 32'(fsm_key), 32'd1);
      chk("idle_kerr", 32'(key_err), 32'd0);
    end

    // Single full burst by A.
    x_a = 5'b10100;
    req = 2'b01;
    tick();
    chk("s_frst_gnt", 32'(gnt), 32'd1);
    chk("s_frst_rst", 32'(fsm_rst), 32'd1);
    chk("s_frst_vld", 32'(y_vld), 32'd0);
    for (int i = 0; i < 8; i++) run_step("s_run", 1'b0, 5'b10100);
    tick();
    idle_chk("s_gap");
    tick();
    idle_chk("s_idle");
    tick();
    chk("s_next_gnt", 32'(gnt), 32'd1);
    chk("s_next_rst", 32'(fsm_rst), 32'd1);

    // Request dropped during FRST: one RUN cycle, then GAP.
    req = 2'b00;
    run_step("d_run", 1'b0, 5'b00011);
    tick();
    idle_chk("d_gap");
    tick();
    idle_chk("d_idle");

    // Contention: alternating owners, B first since A owned last.
    req = 2'b11;
    own = 1'b1;
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("c_frst_gnt", 32'(gnt), own ? 32'd2 : 32'd1);
      chk("c_frst_rst", 32'(fsm_rst), 32'd1);
      for (int i = 0; i < 8; i++) run_step("c_run", own, 5'(b * 7 + i));
      tick();
      idle_chk("c_gap");
      tick();
      idle_chk("c_idle");
      own = ~own;
    end

    // Early release by B after 3 RUN cycles; A follows.
    tick();
    chk("e_frst_gnt", 32'(gnt), 32'd2);
    for (int i = 0; i < 3; i++) run_step("e_run", 1'b1, 5'(i + 20));
    req = 2'b01;
    tick();
    idle_chk("e_gap");
    tick();
    idle_chk("e_idle");
    tick();
    chk("e_nxt_gnt", 32'(gnt), 32'd1);

    // Key write during RUN is rejected and flagged.
    run_step("k_run1", 1'b0, 5'd9);
    key_we = 1'b1; key_din = 1'b0;
    run_step("k_run2", 1'b0, 5'd10);
    chk("k_run_key", 32'(fsm_key), 32'd1);
    chk("k_run_err", 32'(key_err), 32'd1);
    key_we = 1'b0;
    run_step("k_run3", 1'b0, 5'd11);
    chk("k_sticky", 32'(key_err), 32'd1);
    run_step("k_run4", 1'b0, 5'd12);

    // Reset on RUN cycle 4 aborts the burst.
    rst = 1'b0;
    tick();
    idle_chk("m_rst");
    chk("m_key", 32'(fsm_key), 32'd1);
    chk("m_kerr", 32'(key_err), 32'd0);
    chk("m_yout", 32'(y_out), 32'd0);
    chk("m_yown", 32'(y_owner), 32'd0);
    rst = 1'b1; req = 2'b00;
    tick();
    idle_chk("m_idle");

    // Key write in IDLE takes effect next cycle.
    key_we = 1'b1; key_din = 1'b0;
    tick();
    chk("i_key", 32'(fsm_key), 32'd0);
    chk("i_kerr", 32'(key_err), 32'd0);

    // Key write with a new grant; A wins first after reset.
    key_din = 1'b1; req = 2'b11;
    tick();
    key_we = 1'b0;
    chk("g_gnt", 32'(gnt), 32'd1);
    chk("g_key", 32'(fsm_key), 32'd1);
    chk("g_kerr", 32'(key_err), 32'd0);
    req = 2'b00;
    run_step("g_run", 1'b0, 5'd17);
    chk("g_run_key", 32'(fsm_key), 32'd1);
    tick();
    idle_chk("g_gap");
    tick();
    idle_chk("g_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
